// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage sitting directly behind the execute-stage ALU.
//   Takes a LOAD/STORE at start, checks legality and alignment, and then
//   either raises a one-cycle exception pulse or runs a req/ready
//   transaction on the data-memory port. Loads are lane-selected and
//   sign/zero-extended into load_data. Stores are lane-replicated and
//   masked. busy stalls the pipeline while the access is outstanding.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   start, opcode, funct3   instruction presented by the execute stage
//   address, store_data     effective address (ALU result), forwarded rs2
//   mem_req/we/addr/wmask/wdata   data-memory request side
//   mem_ready, mem_rdata    data-memory response side
//   load_data               extended load result, held between loads
//   done, exception         one-cycle completion / fault pulses
//   busy                    pipeline stall, high while in ACCESS
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start with a LOAD/STORE opcode
// ACCESS | memory request outstanding, waiting for mem_ready
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            busy,
  output logic            exception
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]      state;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      wmask_q;
  logic [XLEN-1:0] wdata_q;

  // Decode of the instruction presented in IDLE
  logic            op_load;
  logic            op_store;
  logic            f3_legal;
  logic            misaligned;
  logic            take;
  logic            fault;
  logic [3:0]      wmask_d;
  logic [XLEN-1:0] wdata_d;

  assign op_load  = (opcode == OP_LOAD);
  assign op_store = (opcode == OP_STORE);

  always_comb begin
    f3_legal = 1'b0;
    if (op_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else if (op_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal encoding
  assign misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                      ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));

  assign take  = (state == ST_IDLE) && start && (op_load || op_store);
  assign fault = !f3_legal || misaligned;

  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = '0;
    if (op_store) begin
      case (funct3[1:0])
        2'b00: begin
          wmask_d = 4'b0001 << address[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        2'b01: begin
          wmask_d = address[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          wmask_d = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

  // Load lane select and extension, using the latched address/funct3
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wmask_q    <= 4'b0000;
      wdata_q    <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      exception  <= 1'b0;
    end else begin
      done      <= 1'b0;
      exception <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            if (fault) begin
              exception <= 1'b1;
            end else begin
              state      <= ST_ACCESS;
              is_store_q <= op_store;
              funct3_q   <= funct3;
              addr_q     <= address;
              wmask_q    <= wmask_d;
              wdata_q    <= wdata_d;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            if (!is_store_q) begin
              load_data <= load_ext;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request side is decoded from state so an async reset drops it at once
  assign mem_req   = (state == ST_ACCESS);
  assign busy      = (state == ST_ACCESS);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        exception;

  int tests_run = 0;
  int tests_failed = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .done       (done),
    .busy       (busy),
    .exception  (exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    start      = 1'b1;
    opcode     = op;
    funct3     = f3;
    address    = addr;
    store_data = data;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    address = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    tick();
    check("rst_req",  {31'd0, mem_req},   32'd0);
    check("rst_we",   {31'd0, mem_we},    32'd0);
    check("rst_addr", mem_addr,           32'd0);
    check("rst_mask", {28'd0, mem_wmask}, 32'd0);
    check("rst_wd",   mem_wdata,          32'd0);
    check("rst_ld",   load_data,          32'd0);
    check("rst_flags", {29'd0, done, busy, exception}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: SW 0x100, zero-wait memory
    issue(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF);
    mem_ready = 1'b1;
    tick();
    start = 1'b0;
    check("sw_req",  {31'd0, mem_req},   32'd1);
    check("sw_busy", {31'd0, busy},      32'd1);
    check("sw_we",   {31'd0, mem_we},    32'd1);
    check("sw_addr", mem_addr,           32'h100);
    check("sw_mask", {28'd0, mem_wmask}, 32'hF);
    check("sw_wd",   mem_wdata,          32'hDEADBEEF);
    check("sw_done_early", {31'd0, done}, 32'd0);
    tick();
    check("sw_done", {31'd0, done},    32'd1);
    check("sw_idle", {31'd0, mem_req}, 32'd0);
    tick();
    check("sw_done_pulse", {31'd0, done}, 32'd0);

    // 2: SB 0x103 with one wait state
    mem_ready = 1'b0;
    issue(OP_STORE, 3'b000, 32'h103, 32'h000000A5);
    tick();
    start = 1'b0;
    check("sb_mask", {28'd0, mem_wmask}, 32'h8);
    check("sb_wd",   mem_wdata,          32'hA5A5A5A5);
    check("sb_we",   {31'd0, mem_we},    32'd1);
    check("sb_addr", mem_addr,           32'h100);
    tick();
    check("sb_wait_req",  {31'd0, mem_req}, 32'd1);
    check("sb_wait_done", {31'd0, done},    32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sb_done", {31'd0, done}, 32'd1);
    check("sb_ld_kept", load_data, 32'd0);

    // SH upper half
    issue(OP_STORE, 3'b001, 32'h202, 32'h0000BEEF);
    tick();
    start = 1'b0;
    check("sh_mask", {28'd0, mem_wmask}, 32'hC);
    check("sh_wd",   mem_wdata,          32'hBEEFBEEF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sh_done", {31'd0, done}, 32'd1);

    // 3: LB 0x102, three wait states
    mem_rdata = 32'h12F45678;
    issue(OP_LOAD, 3'b000, 32'h102, 32'h0);
    tick();
    start = 1'b0;
    check("lb_busy1", {31'd0, busy},      32'd1);
    check("lb_we",    {31'd0, mem_we},    32'd0);
    check("lb_mask",  {28'd0, mem_wmask}, 32'h0);
    check("lb_addr",  mem_addr,           32'h100);
    tick();
    check("lb_busy2", {31'd0, busy}, 32'd1);
    tick();
    check("lb_busy3", {31'd0, busy}, 32'd1);
    tick();
    check("lb_busy4", {31'd0, busy}, 32'd1);
    check("lb_nodone", {31'd0, done}, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_busy_off", {31'd0, busy}, 32'd0);
    check("lb_data", load_data, 32'hFFFFFFF4);

    // LBU repeat
    issue(OP_LOAD, 3'b100, 32'h102, 32'h0);
    mem_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("lbu_done", {31'd0, done}, 32'd1);
    check("lbu_data", load_data, 32'h000000F4);

    // LH upper half sign-extended, LHU lower half
    mem_rdata = 32'h8001_7FFE;
    issue(OP_LOAD, 3'b001, 32'h302, 32'h0);
    tick();
    start = 1'b0;
    tick();
    check("lh_data", load_data, 32'hFFFF8001);
    issue(OP_LOAD, 3'b101, 32'h300, 32'h0);
    tick();
    start = 1'b0;
    tick();
    check("lhu_data", load_data, 32'h00007FFE);

    // Store must leave load_data alone
    issue(OP_STORE, 3'b010, 32'h40, 32'h12345678);
    tick();
    start = 1'b0;
    tick();
    check("st_done", {31'd0, done}, 32'd1);
    check("st_ld_kept", load_data, 32'h00007FFE);
    mem_ready = 1'b0;

    // 4: misaligned LH, illegal funct3, non-memory opcode
    issue(OP_LOAD, 3'b001, 32'h101, 32'h0);
    tick();
    start = 1'b0;
    check("lh_mis_exc", {31'd0, exception}, 32'd1);
    check("lh_mis_req", {31'd0, mem_req},   32'd0);
    check("lh_mis_done", {31'd0, done},     32'd0);
    tick();
    check("exc_pulse", {31'd0, exception}, 32'd0);
    check("exc_no_req", {31'd0, mem_req},  32'd0);
    issue(OP_LOAD, 3'b011, 32'h100, 32'h0);
    tick();
    start = 1'b0;
    check("ld_f3_011_exc", {31'd0, exception}, 32'd1);
    check("ld_f3_011_req", {31'd0, mem_req},   32'd0);
    issue(OP_STORE, 3'b010, 32'h102, 32'h0);
    tick();
    start = 1'b0;
    check("sw_mis_exc", {31'd0, exception}, 32'd1);
    issue(OP_STORE, 3'b100, 32'h100, 32'h0);
    tick();
    start = 1'b0;
    check("st_f3_100_exc", {31'd0, exception}, 32'd1);
    issue(OP_ALU, 3'b011, 32'h101, 32'h0);
    tick();
    start = 1'b0;
    check("alu_ign", {30'd0, mem_req, exception}, 32'd0);

    // 5: async reset mid-access
    issue(OP_LOAD, 3'b010, 32'h8, 32'h0);
    tick();
    start = 1'b0;
    check("rst_acc_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_req",  {31'd0, mem_req}, 32'd0);
    check("rst_async_busy", {31'd0, busy},    32'd0);
    #1 reset = 1'b0;
    tick();
    check("rst_no_done", {30'd0, done, mem_req}, 32'd0);
    mem_rdata = 32'hCAFEBABE;
    mem_ready = 1'b1;
    issue(OP_LOAD, 3'b010, 32'h8, 32'h0);
    tick();
    start = 1'b0;
    check("lw8_req",  {31'd0, mem_req}, 32'd1);
    check("lw8_addr", mem_addr,         32'h8);
    tick();
    mem_ready = 1'b0;
    check("lw8_done", {31'd0, done}, 32'd1);
    check("lw8_data", load_data,     32'hCAFEBABE);

    // 6: start while busy is ignored
    mem_rdata = 32'h11223344;
    issue(OP_LOAD, 3'b010, 32'h10, 32'h0);
    tick();
    issue(OP_STORE, 3'b010, 32'h20, 32'h55);
    tick();
    start = 1'b0;
    check("busy_ign_we",   {31'd0, mem_we}, 32'd0);
    check("busy_ign_addr", mem_addr,        32'h10);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("busy_ign_done", {31'd0, done}, 32'd1);
    check("busy_ign_data", load_data,     32'h11223344);
    check("busy_ign_req",  {31'd0, mem_req}, 32'd0);
    tick();
    check("busy_ign_req2", {30'd0, mem_req, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
